siren_gen: RTL and testbench

Parametrised multi-mode siren/tone generator for the TinyFPGA BX (16 MHz) MusicBox designs. It drives a single square-wave speaker pin. The pitch is a divider word built from a swept ramp, selectable as steady tone, wail (triangle sweep), yelp (fast sawtooth) or hi-lo (two-tone alternation). It has an enable and a debug view of the live divider and sweep phase, and sits directly between the top-level mode/enable controls and the piezo pin.

---
 rtl/siren_gen.sv | 97 +++++++++
 tb/tb_siren_gen.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/siren_gen.sv
// Multi-mode siren generator: a swept ramp builds a divider word that sets the
// half-period of a square wave on the speaker pin (steady, wail, yelp, hi-lo).
module siren_gen #(
    parameter int PRESC_W    = 15,
    parameter int RAMP_W     = 7,
    parameter int LOW_W      = 6,
    parameter int YELP_SHIFT = 5
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      EN,
    input  logic [1:0]                MODE,
    output logic                      SPEAKER,
    output logic                      PHASE,
    output logic [RAMP_W+LOW_W+1:0]   DIV
);

    localparam int DIV_W  = 2 + RAMP_W + LOW_W;
    localparam int FAST_W = PRESC_W - YELP_SHIFT;

    localparam logic [1:0] MODE_STEADY = 2'd0;
    localparam logic [1:0] MODE_WAIL   = 2'd1;
    localparam logic [1:0] MODE_YELP   = 2'd2;
    localparam logic [1:0] MODE_HILO   = 2'd3;

    logic [PRESC_W-1:0] presc_reg;
    logic [RAMP_W-1:0]  cnt_reg;
    logic               dir_reg;
    logic [1:0]         mode_q_reg;
    logic [DIV_W-1:0]   tone_reg;
    logic               speaker_reg;
    logic [DIV_W-1:0]   div_reg;

    logic               slow_tick;
    logic               fast_tick;
    logic               ramp_step;
    logic [RAMP_W-1:0]  ramp_val;
    logic [DIV_W-1:0]   div_next;

    assign slow_tick = EN & (&presc_reg);
    assign fast_tick = EN & (&presc_reg[FAST_W-1:0]);
    assign ramp_step = (mode_q_reg == MODE_YELP) ? fast_tick : slow_tick;

    always_comb begin
        ramp_val = '0;
        case (mode_q_reg)
            MODE_WAIL: ramp_val = dir_reg ? cnt_reg : ~cnt_reg;
            MODE_YELP: ramp_val = cnt_reg;
            MODE_HILO: ramp_val = dir_reg ? {1'b1, {(RAMP_W-1){1'b0}}} : '0;
            default:   ramp_val = '0;
        endcase
    end

    assign div_next = {2'b01, ramp_val, {LOW_W{1'b0}}};

    // Prescaler, ramp and mode register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc_reg  <= '0;
            cnt_reg    <= '0;
            dir_reg    <= 1'b0;
            mode_q_reg <= MODE_STEADY;
        end else begin
            mode_q_reg <= MODE;
            if (EN)
                presc_reg <= presc_reg + 1'b1;
            if (ramp_step) begin
                cnt_reg <= cnt_reg + 1'b1;
                if (&cnt_reg)
                    dir_reg <= ~dir_reg;
            end
        end
    end

    // The divider word is only sampled at reload, so a half-period never shrinks
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tone_reg    <= '0;
            speaker_reg <= 1'b0;
            div_reg     <= '0;
        end else if (!EN) begin
            tone_reg    <= '0;
            speaker_reg <= 1'b0;
        end else if (tone_reg == '0) begin
            tone_reg    <= div_next;
            div_reg     <= div_next;
            speaker_reg <= ~speaker_reg;
        end else begin
            tone_reg <= tone_reg - 1'b1;
        end
    end

    assign SPEAKER = speaker_reg;
    assign PHASE   = dir_reg;
    assign DIV     = div_reg;

endmodule

// File: tb/tb_siren_gen.sv
// Self-checking bench for siren_gen: directed scenarios plus random mode/enable
// segments, each cycle compared with an arithmetic reference model.
module tb_siren_gen;

    localparam int PRESC_W    = 4;
    localparam int RAMP_W     = 3;
    localparam int LOW_W      = 1;
    localparam int YELP_SHIFT = 2;
    localparam int DIV_W      = 2 + RAMP_W + LOW_W;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             EN  = 1'b0;
    logic [1:0]       MODE = 2'd0;
    logic             SPEAKER;
    logic             PHASE;
    logic [DIV_W-1:0] DIV;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model state, plain integers
    int m_p, m_cnt, m_dir, m_mq, m_tc, m_spk, m_div;

    siren_gen #(
        .PRESC_W   (PRESC_W),
        .RAMP_W    (RAMP_W),
        .LOW_W     (LOW_W),
        .YELP_SHIFT(YELP_SHIFT)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .EN     (EN),
        .MODE   (MODE),
        .SPEAKER(SPEAKER),
        .PHASE  (PHASE),
        .DIV    (DIV)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_p = 0; m_cnt = 0; m_dir = 0; m_mq = 0; m_tc = 0; m_spk = 0; m_div = 0;
    endtask

    // One clock edge of behaviour, using the pre-edge state and inputs
    task automatic model_step();
        int  ramp, d, pres_len, fast_len;
        bit  step;
        pres_len = 1 << PRESC_W;
        fast_len = 1 << (PRESC_W - YELP_SHIFT);
        case (m_mq)
            1:       ramp = m_dir ? m_cnt : (1 << RAMP_W) - 1 - m_cnt;
            2:       ramp = m_cnt;
            3:       ramp = m_dir ? (1 << (RAMP_W - 1)) : 0;
            default: ramp = 0;
        endcase
        d = (1 << (RAMP_W + LOW_W)) + ramp * (1 << LOW_W);
        if (EN) begin
            if (m_mq == 2) step = (m_p % fast_len) == fast_len - 1;
            else           step = m_p == pres_len - 1;
            m_p = (m_p + 1) % pres_len;
            if (step) begin
                if (m_cnt == (1 << RAMP_W) - 1) m_dir = 1 - m_dir;
                m_cnt = (m_cnt + 1) % (1 << RAMP_W);
            end
            if (m_tc == 0) begin
                m_tc = d; m_div = d; m_spk = 1 - m_spk;
            end else begin
                m_tc = m_tc - 1;
            end
        end else begin
            m_tc = 0; m_spk = 0;
        end
        m_mq = MODE;
    endtask

    task automatic cycle();
        @(posedge CLK);
        if (!RST) model_step();
        @(negedge CLK);
        cyc++;
        check_eq("speaker", SPEAKER, m_spk);
        check_eq("div", DIV, m_div);
        check_eq("phase", PHASE, m_dir);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Cycles until SPEAKER changes, bounded
    task automatic wait_toggle(input string tag, output int n);
        logic prev;
        prev = SPEAKER;
        n = 0;
        do begin
            cycle();
            n++;
        end while (SPEAKER == prev && n < 100);
        if (SPEAKER == prev) check_eq({tag, "_timeout"}, SPEAKER, !prev);
    endtask

    initial begin
        int n;
        model_reset();
        repeat (3) @(negedge CLK);
        check_eq("rst_speaker", SPEAKER, 0);
        check_eq("rst_div", DIV, 0);
        check_eq("rst_phase", PHASE, 0);
        RST = 1'b0;

        // steady tone: 17-cycle half-period
        EN = 1'b1; MODE = 2'd0;
        run(40);
        wait_toggle("steady", n);
        wait_toggle("steady", n);
        check_eq("steady_half", n, 17);
        check_eq("steady_div", DIV, 16);
        $display("seg steady: half=%0d div=%0d", n, DIV);

        // mode switch mid half-period: current half-period keeps old pitch
        wait_toggle("switch", n);
        run(5);
        MODE = 2'd3;
        wait_toggle("switch", n);
        check_eq("switch_half", n + 5, 17);
        $display("seg steady->hilo: half=%0d", n + 5);
        run(300);
        $display("seg hilo: phase=%0d div=%0d", PHASE, DIV);

        MODE = 2'd1; run(300);
        $display("seg wail: phase=%0d div=%0d", PHASE, DIV);
        MODE = 2'd2; run(120);
        $display("seg yelp: phase=%0d div=%0d", PHASE, DIV);

        // enable drop and re-assert
        run(7);
        EN = 1'b0;
        cycle();
        check_eq("en_off_speaker", SPEAKER, 0);
        run(10);
        EN = 1'b1;
        cycle();
        check_eq("en_on_speaker", SPEAKER, 1);
        run(30);
        $display("seg enable toggle: div=%0d", DIV);

        // asynchronous reset between edges
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        check_eq("async_speaker", SPEAKER, 0);
        check_eq("async_div", DIV, 0);
        check_eq("async_phase", PHASE, 0);
        model_reset();
        run(3);
        RST = 1'b0;
        MODE = 2'd1;
        run(50);
        $display("seg async reset: div=%0d", DIV);

        // random segments
        for (int s = 0; s < 40; s++) begin
            int len;
            MODE = 2'($urandom_range(0, 3));
            EN   = ($urandom_range(0, 5) != 0);
            len  = $urandom_range(1, 80);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 30) == 0) MODE = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 40) == 0) EN = ~EN;
                cycle();
            end
            $display("seg rand %0d: mode=%0d en=%0d len=%0d div=%0d phase=%0d",
                     s, MODE, EN, len, DIV, PHASE);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
